// File: rtl/response_system_pkg.sv
// -----------------------------------------------------------------------------
// response_system_pkg
// Shared constants and helpers for the service-hall ticket calling system.
//   NUM_DESKS        : number of service desks (A..E)
//   TICKET_W         : width of a ticket number (tickets 1..63, 0 = none)
//   WAIT_W           : width of the waiting-ticket counter
//   DESK_NONE..DESK_E: encodings driven on counter_call
//   ticket_inc()     : next ticket number, wrapping 63 -> 1 (0 never issued)
// -----------------------------------------------------------------------------
package response_system_pkg;

    localparam int NUM_DESKS = 5;
    localparam int TICKET_W  = 6;
    localparam int WAIT_W    = 4;

    typedef logic [2:0] desk_idx_t;

    localparam desk_idx_t DESK_NONE = 3'd0;
    localparam desk_idx_t DESK_A    = 3'd1;
    localparam desk_idx_t DESK_B    = 3'd2;
    localparam desk_idx_t DESK_C    = 3'd3;
    localparam desk_idx_t DESK_D    = 3'd4;
    localparam desk_idx_t DESK_E    = 3'd5;

    // Ticket 0 means "none", so the all-ones value wraps back to 1.
    function automatic logic [TICKET_W-1:0] ticket_inc(input logic [TICKET_W-1:0] t);
        if (t == {TICKET_W{1'b1}}) begin
            return {{(TICKET_W-1){1'b0}}, 1'b1};
        end
        return t + 1'b1;
    endfunction

endpackage : response_system_pkg

// File: rtl/service_desk.sv
// -----------------------------------------------------------------------------
// service_desk
// One service desk: when started it latches the ticket it is serving and stays
// busy for SERVICE_CYCLES clock cycles, then returns to idle while still
// showing the last ticket served.
// Ports:
//   clk           in  system clock, rising edge
//   rst           in  asynchronous active-low reset
//   start         in  one-cycle dispatch strobe (only asserted while idle)
//   ticket        in  ticket number captured on start
//   busy          out 1 = serving a ticket
//   serviceNumber out ticket currently or last served (0 = never used)
// -----------------------------------------------------------------------------
module service_desk
    import response_system_pkg::*;
#(
    parameter int SERVICE_CYCLES = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TICKET_W-1:0] ticket,
    output logic                busy,
    output logic [TICKET_W-1:0] serviceNumber
);

    localparam int TIMER_W = $clog2(SERVICE_CYCLES + 1);

    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                busy_q, busy_d;
    logic [TICKET_W-1:0] num_q, num_d;

    always_comb begin
        timer_d = timer_q;
        busy_d  = busy_q;
        num_d   = num_q;
        if (start) begin
            timer_d = TIMER_W'(SERVICE_CYCLES);
            busy_d  = 1'b1;
            num_d   = ticket;
        end else if (busy_q) begin
            timer_d = timer_q - 1'b1;
            // Busy drops on the same edge the timer reaches zero.
            if (timer_q == TIMER_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
            busy_q  <= 1'b0;
            num_q   <= '0;
        end else begin
            timer_q <= timer_d;
            busy_q  <= busy_d;
            num_q   <= num_d;
        end
    end

    assign busy          = busy_q;
    assign serviceNumber = num_q;

endmodule : service_desk

// File: rtl/response_system_top.sv
// -----------------------------------------------------------------------------
// response_system_top
// Queue-ticket calling system for five service desks A..E. A rising edge on
// the sampled button issues the next ticket; waiting tickets are handed, in
// issue order, to idle desks, at most one per cycle.
//
// Optional build macro RESPONSE_SYS_ROUND_ROBIN_EN:
//   defined   -> idle-desk search is round-robin, starting after the last desk
//                called (pointer resets to E so the first call goes to A)
//   undefined -> fixed priority A > B > C > D > E
//
// Ports:
//   clk                 in  system clock, rising edge
//   rst                 in  asynchronous active-low reset
//   button              in  ticket request, sampled on clk
//   current_number      out issued, not-yet-dispatched tickets
//   counterA..counterE  out desk busy flags
//   number_service      out last ticket issued (0 = none yet)
//   counter_call        out desk called this cycle, 1..5 = A..E, 0 = none
//   A..E_serviceNumber  out ticket currently or last served at each desk
// -----------------------------------------------------------------------------
module response_system_top
    import response_system_pkg::*;
#(
    parameter int SERVICE_CYCLES = 12,
    parameter int MAX_WAIT       = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    output logic [WAIT_W-1:0]   current_number,
    output logic                counterA,
    output logic                counterB,
    output logic                counterC,
    output logic                counterD,
    output logic                counterE,
    output logic [TICKET_W-1:0] number_service,
    output logic [2:0]          counter_call,
    output logic [TICKET_W-1:0] A_serviceNumber,
    output logic [TICKET_W-1:0] B_serviceNumber,
    output logic [TICKET_W-1:0] C_serviceNumber,
    output logic [TICKET_W-1:0] D_serviceNumber,
    output logic [TICKET_W-1:0] E_serviceNumber
);

    // ---------------- registers ----------------
    logic                btn_q;
    logic [TICKET_W-1:0] issue_ptr_q, issue_ptr_d;
    logic [TICKET_W-1:0] serve_ptr_q, serve_ptr_d;
    logic [WAIT_W-1:0]   cur_q, cur_d;
    logic [TICKET_W-1:0] ns_q, ns_d;
    desk_idx_t           call_q, call_d;

    // ---------------- desk interface ----------------
    logic [NUM_DESKS-1:0] desk_busy;
    logic [NUM_DESKS-1:0] desk_start;
    logic [TICKET_W-1:0]  desk_num [NUM_DESKS];

    // ---------------- arbiter ----------------
    logic       grant_valid;
    logic [2:0] grant_idx;   // 0-based desk index (0 = A)
    logic       press;
    logic       accept;
    logic       fire;

    assign press  = button & ~btn_q;
    assign accept = press && (cur_q < WAIT_W'(MAX_WAIT));

`ifdef RESPONSE_SYS_ROUND_ROBIN_EN
    logic [2:0] last_q, last_d;
    logic [2:0] rr_cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_cand     = '0;
        // Walk the desks starting one past the last desk called.
        for (int k = 1; k <= NUM_DESKS; k++) begin
            rr_cand = 3'((int'(last_q) + k) % NUM_DESKS);
            if (!grant_valid && !desk_busy[rr_cand]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (fire) begin
            last_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 3'(NUM_DESKS - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Scan from E down to A so the lowest-letter idle desk wins.
        for (int k = NUM_DESKS - 1; k >= 0; k--) begin
            if (!desk_busy[k]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(k);
            end
        end
    end
`endif

    assign fire       = grant_valid && (cur_q != '0);
    assign desk_start = fire ? (NUM_DESKS'(1) << grant_idx) : '0;

    // ---------------- next state ----------------
    always_comb begin
        issue_ptr_d = issue_ptr_q;
        serve_ptr_d = serve_ptr_q;
        cur_d       = cur_q;
        ns_d        = ns_q;
        call_d      = DESK_NONE;

        if (accept) begin
            ns_d        = issue_ptr_q;
            issue_ptr_d = ticket_inc(issue_ptr_q);
        end

        if (fire) begin
            serve_ptr_d = ticket_inc(serve_ptr_q);
            call_d      = grant_idx + 3'd1;
        end

        // A press and a dispatch on the same edge cancel in the count.
        case ({accept, fire})
            2'b10:   cur_d = cur_q + WAIT_W'(1);
            2'b01:   cur_d = cur_q - WAIT_W'(1);
            default: cur_d = cur_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q       <= 1'b0;
            issue_ptr_q <= TICKET_W'(1);
            serve_ptr_q <= TICKET_W'(1);
            cur_q       <= '0;
            ns_q        <= '0;
            call_q      <= DESK_NONE;
        end else begin
            btn_q       <= button;
            issue_ptr_q <= issue_ptr_d;
            serve_ptr_q <= serve_ptr_d;
            cur_q       <= cur_d;
            ns_q        <= ns_d;
            call_q      <= call_d;
        end
    end

    // ---------------- desks ----------------
    for (genvar g = 0; g < NUM_DESKS; g++) begin : g_desk
        service_desk #(
            .SERVICE_CYCLES (SERVICE_CYCLES)
        ) u_desk (
            .clk           (clk),
            .rst           (rst),
            .start         (desk_start[g]),
            .ticket        (serve_ptr_q),
            .busy          (desk_busy[g]),
            .serviceNumber (desk_num[g])
        );
    end

    // ---------------- outputs ----------------
    assign current_number  = cur_q;
    assign number_service  = ns_q;
    assign counter_call    = call_q;
    assign counterA        = desk_busy[0];
    assign counterB        = desk_busy[1];
    assign counterC        = desk_busy[2];
    assign counterD        = desk_busy[3];
    assign counterE        = desk_busy[4];
    assign A_serviceNumber = desk_num[0];
    assign B_serviceNumber = desk_num[1];
    assign C_serviceNumber = desk_num[2];
    assign D_serviceNumber = desk_num[3];
    assign E_serviceNumber = desk_num[4];

endmodule : response_system_top

// File: tb/tb_response_system_top.sv
// -----------------------------------------------------------------------------
// tb_response_system_top
// Self-checking bench for response_system_top. A behavioural model of the
// ticket hall predicts every output each cycle; issued tickets are pushed to
// exp_q and popped whenever the DUT calls a desk, so the dispatch order is
// checked against the issue order independently of the model's serve pointer.
// -----------------------------------------------------------------------------
module tb_response_system_top;

    localparam int SC   = 12;
    localparam int MAXW = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic button = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [3:0] current_number;
    logic       counterA, counterB, counterC, counterD, counterE;
    logic [5:0] number_service;
    logic [2:0] counter_call;
    logic [5:0] A_serviceNumber, B_serviceNumber, C_serviceNumber;
    logic [5:0] D_serviceNumber, E_serviceNumber;

    response_system_top #(
        .SERVICE_CYCLES (SC),
        .MAX_WAIT       (MAXW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .button          (button),
        .current_number  (current_number),
        .counterA        (counterA),
        .counterB        (counterB),
        .counterC        (counterC),
        .counterD        (counterD),
        .counterE        (counterE),
        .number_service  (number_service),
        .counter_call    (counter_call),
        .A_serviceNumber (A_serviceNumber),
        .B_serviceNumber (B_serviceNumber),
        .C_serviceNumber (C_serviceNumber),
        .D_serviceNumber (D_serviceNumber),
        .E_serviceNumber (E_serviceNumber)
    );

    logic [4:0] busy_v;
    logic [5:0] svc_v [5];
    assign busy_v   = {counterE, counterD, counterC, counterB, counterA};
    assign svc_v[0] = A_serviceNumber;
    assign svc_v[1] = B_serviceNumber;
    assign svc_v[2] = C_serviceNumber;
    assign svc_v[3] = D_serviceNumber;
    assign svc_v[4] = E_serviceNumber;

    // ---------------- scoreboard ----------------
    logic [5:0] exp_q[$];
    int n_vec  = 0;
    int n_err  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_cur, m_issue, m_serve, m_ns, m_call, m_last;
    int m_rem [5];
    int m_svc [5];
    bit m_btn;

    function automatic int next_ticket(input int t);
        return (t == 63) ? 1 : t + 1;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_issue = 1; m_serve = 1; m_ns = 0; m_call = 0;
        m_last = 4; m_btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_rem[i] = 0;
            m_svc[i] = 0;
        end
        exp_q.delete();
    endtask

    // Advance the model by one rising edge with button value b.
    task automatic model_step(input bit b);
        bit press, accept, fire;
        int sel;
        press  = b && !m_btn;
        m_btn  = b;
        accept = press && (m_cur < MAXW);
        sel    = -1;
`ifdef RESPONSE_SYS_ROUND_ROBIN_EN
        for (int k = 1; k <= 5; k++) begin
            int c;
            c = (m_last + k) % 5;
            if (sel < 0 && m_rem[c] == 0) sel = c;
        end
`else
        for (int k = 0; k < 5; k++) begin
            if (sel < 0 && m_rem[k] == 0) sel = k;
        end
`endif
        fire = (m_cur > 0) && (sel >= 0);
        for (int i = 0; i < 5; i++) begin
            if (m_rem[i] > 0) m_rem[i]--;
        end
        if (fire) begin
            m_rem[sel] = SC;
            m_svc[sel] = m_serve;
            m_serve    = next_ticket(m_serve);
            m_call     = sel + 1;
            m_last     = sel;
        end else begin
            m_call = 0;
        end
        if (accept) begin
            m_ns = m_issue;
            exp_q.push_back(6'(m_issue));
            m_issue = next_ticket(m_issue);
        end
        m_cur = m_cur + int'(accept) - int'(fire);
    endtask

    // Compare every DUT output against the model and service the scoreboard.
    task automatic compare_all();
        logic [5:0] exp_t;
        check("current_number", 32'(current_number), 32'(m_cur));
        check("number_service", 32'(number_service), 32'(m_ns));
        check("counter_call",   32'(counter_call),   32'(m_call));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("busy_%0d", i), 32'(busy_v[i]), 32'(m_rem[i] > 0));
            check($sformatf("svc_%0d", i),  32'(svc_v[i]),  32'(m_svc[i]));
        end
        if (counter_call != 3'd0) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else if (counter_call > 3'd5) begin
                check("sb_call_range", 32'(counter_call), 32'd5);
                void'(exp_q.pop_front());
            end else begin
                exp_t = exp_q.pop_front();
                check("sb_order", 32'(svc_v[counter_call - 3'd1]), 32'(exp_t));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit b);
        button = b;
        @(posedge clk);
        model_step(b);
        #1;
        compare_all();
    endtask

    // Asynchronous reset, checked while still held low, then released.
    task automatic do_reset();
        button = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int max_cur;

    initial begin
        model_reset();
        // Reset held from time 0.
        repeat (3) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        rst = 1'b1;
        repeat (4) cycle(1'b0);

        // Single press: ticket 1 then desk A one edge later.
        cycle(1'b1);
        check("single_ns", 32'(number_service), 32'd1);
        check("single_cur", 32'(current_number), 32'd1);
        cycle(1'b0);
        check("single_A_busy", 32'(counterA), 32'd1);
        check("single_A_num", 32'(A_serviceNumber), 32'd1);
        check("single_call", 32'(counter_call), 32'd1);
        check("single_cur0", 32'(current_number), 32'd0);
        cycle(1'b0);
        check("single_call0", 32'(counter_call), 32'd0);
        repeat (15) cycle(1'b0);

        // Seven presses back to back.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1);
            cycle(1'b0);
        end
        check("seven_ns", 32'(number_service), 32'd7);
        check("seven_cur", 32'(current_number), 32'd2);
        check("seven_A", 32'(A_serviceNumber), 32'd1);
        check("seven_E", 32'(E_serviceNumber), 32'd5);
        repeat (30) cycle(1'b0);
        check("seven_A_next", 32'(A_serviceNumber), 32'd6);
        check("seven_B_next", 32'(B_serviceNumber), 32'd7);
        check("seven_cur_end", 32'(current_number), 32'd0);

        // Saturation of the waiting counter.
        do_reset();
        max_cur = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(1'b1);
            if (int'(current_number) > max_cur) max_cur = int'(current_number);
            cycle(1'b0);
        end
        check("sat_peak", 32'(max_cur), 32'd15);
        repeat (60) cycle(1'b0);

        // Random button activity.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)));
        end

        // Reset in the middle of service.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            cycle(1'b0);
        end
        check("midrst_busy", 32'(counterA), 32'd1);
        do_reset();
        check("midrst_ns", 32'(number_service), 32'd0);
        check("midrst_busyv", 32'(busy_v), 32'd0);
        cycle(1'b0);
        cycle(1'b1);
        check("post_ns", 32'(number_service), 32'd1);
        cycle(1'b0);
        check("post_A", 32'(A_serviceNumber), 32'd1);
        check("post_call", 32'(counter_call), 32'd1);

        repeat (30) cycle(1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_response_system_top
